// File: rtl/arb_pkg.sv
// arb_pkg: shared state/owner types and write-enable codes for memory_arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;
endpackage

// File: rtl/arb_select.sv
// arb_select: winner pick between IF and D; ARB_ROUND_ROBIN_EN selects round-robin, otherwise D has fixed priority
module arb_select import arb_pkg::*; (
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  arb_owner_t last_owner_i,
  output logic       valid_o,
  output arb_owner_t owner_o
);
  // With no requester the owner output idles at last_owner; valid_o masks it
  always_comb begin
    valid_o = if_req_i | d_req_i;
`ifdef ARB_ROUND_ROBIN_EN
    owner_o = (if_req_i && d_req_i) ? ((last_owner_i == OWN_D) ? OWN_IF : OWN_D) :
              d_req_i ? OWN_D : (if_req_i ? OWN_IF : last_owner_i);
`else
    owner_o = d_req_i ? OWN_D : (if_req_i ? OWN_IF : last_owner_i);
`endif
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between fetch and load/store; ARB_ROUND_ROBIN_EN enables round-robin arbitration
module memory_arbiter import arb_pkg::*; #(
  parameter int RegBits = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               if_req_i,
  input  logic [RegBits-1:0] if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [RegBits-1:0] if_rdata_o,
  input  logic               d_req_i,
  input  logic [1:0]         d_we_i,
  input  logic [RegBits-1:0] d_addr_i,
  input  logic [RegBits-1:0] d_wdata_i,
  output logic               d_gnt_o,
  output logic               d_rvalid_o,
  output logic [RegBits-1:0] d_rdata_o,
  output logic               mem_req_o,
  output logic [1:0]         mem_we_o,
  output logic [RegBits-1:0] mem_addr_o,
  output logic [RegBits-1:0] mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [RegBits-1:0] mem_rdata_i
);
  arb_state_t         state_q, state_d;
  arb_owner_t         owner_q, owner_d, win_owner;
  logic               win_valid, gnt;
  logic               mem_req_q, mem_req_d, if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [1:0]         mem_we_q, mem_we_d;
  logic [RegBits-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [RegBits-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  arb_select u_sel (
    .if_req_i     (if_req_i),
    .d_req_i      (d_req_i),
    .last_owner_i (owner_q),
    .valid_o      (win_valid),
    .owner_o      (win_owner)
  );

  // Grant outside BUSY, latch the winner's payload, capture the response on ack
  always_comb begin
    gnt         = (state_q != BUSY) && win_valid;
    if_gnt_o    = gnt && (win_owner == OWN_IF);
    d_gnt_o     = gnt && (win_owner == OWN_D);
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if (gnt) begin
      state_d     = BUSY;
      owner_d     = win_owner;
      mem_req_d   = 1'b1;
      mem_we_d    = d_gnt_o ? d_we_i : WE_NONE;
      mem_addr_d  = d_gnt_o ? d_addr_i : if_addr_i;
      mem_wdata_d = d_gnt_o ? d_wdata_i : '0;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (state_q == BUSY && mem_ack_i) begin
      state_d     = RESP;
      mem_req_d   = 1'b0;
      if_rvalid_d = (owner_q == OWN_IF);
      d_rvalid_d  = (owner_q == OWN_D);
      if_rdata_d  = (owner_q == OWN_IF) ? mem_rdata_i : if_rdata_q;
      d_rdata_d   = (owner_q != OWN_D) ? d_rdata_q :
                    (mem_we_q inside {WE_BYTE, WE_HALF, WE_WORD}) ? '0 : mem_rdata_i;
    end
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= WE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and random stimulus checked against a transaction-level model
module tb_memory_arbiter;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        if_req_i = 1'b0, d_req_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [1:0]  d_we_i = '0;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  mem_we_o;
  int          vectors = 0, miscompares = 0;

  memory_arbiter #(.RegBits(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Model: one outstanding transaction (m_busy) and a pending response pulse per requester
  logic        m_busy, m_d_owner, m_last, m_if_rv, m_d_rv, m_if_g, m_d_g;
  logic [1:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

  task automatic m_reset();
    m_busy = 0; m_d_owner = 0; m_last = 1; m_if_rv = 0; m_d_rv = 0; m_if_g = 0; m_d_g = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic [1:0] dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic ak, input logic [31:0] rd);
    logic pref_if, rsp;
    @(negedge clk);
    if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dd;
    mem_ack_i = ak; mem_rdata_i = rd;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    pref_if = m_last;
`else
    pref_if = 1'b0;
`endif
    m_if_g = !m_busy && ir && (!dr || pref_if);
    m_d_g  = !m_busy && dr && !m_if_g;
    chk("if_gnt", if_gnt_o, m_if_g);
    chk("d_gnt", d_gnt_o, m_d_g);
    chk("mem_req", mem_req_o, m_busy);
    chk("mem_we", mem_we_o, m_we);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("if_rvalid", if_rvalid_o, m_if_rv);
    chk("d_rvalid", d_rvalid_o, m_d_rv);
    chk("if_rdata", if_rdata_o, m_if_rdata);
    chk("d_rdata", d_rdata_o, m_d_rdata);
    rsp = m_busy && ak;
    m_if_rv = rsp && !m_d_owner;
    m_d_rv  = rsp && m_d_owner;
    if (m_if_rv) m_if_rdata = rd;
    if (m_d_rv) m_d_rdata = (m_we == 2'b00) ? rd : 32'h0;
    if (rsp) m_busy = 0;
    else if (m_if_g || m_d_g) begin
      m_busy = 1; m_d_owner = m_d_g; m_last = m_d_g;
      m_we = m_d_g ? dw : 2'b00;
      m_addr = m_d_g ? da : ia;
      m_wdata = m_d_g ? dd : 32'h0;
    end
  endtask

  task automatic idle(input logic ak);
    cycle(0, 0, 0, 0, 0, 0, ak, $urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (m_busy || m_if_rv || m_d_rv); n++) idle(m_busy);
    chk("drain_idle", {m_busy, m_if_rv, m_d_rv}, 0);
  endtask

  logic        ip, dp;
  logic [31:0] ia, da, dd;
  logic [1:0]  dw;
  logic [3:0]  exp4;
  int          wc, k;
  logic        ak, was_busy;

  initial begin
    m_reset();
    idle(0);
    rst_i = 0;
    // Idle after reset: nothing moves
    for (int n = 0; n < 5; n++) begin
      idle(0);
      chk("t1_mem_req", mem_req_o, 0);
    end
    // Fetch with 3-cycle ack latency
    cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t2_if_gnt", if_gnt_o, 1);
    idle(0);
    chk("t2_mem_req", mem_req_o, 1);
    chk("t2_mem_addr", mem_addr_o, 32'h100);
    idle(0);
    idle(0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    idle(0);
    chk("t2_if_rvalid", if_rvalid_o, 1);
    chk("t2_if_rdata", if_rdata_o, 32'hDEADBEEF);
    // Both requesters held, ack latency 1; last owner is IF here
`ifdef ARB_ROUND_ROBIN_EN
    exp4 = 4'b0101;
`else
    exp4 = 4'b1111;
`endif
    k = 0;
    for (int n = 0; n < 40 && k < 4; n++) begin
      cycle(1, 32'h200, 1, 2'b00, 32'h300, 0, m_busy, $urandom);
      if (m_if_g || m_d_g) begin
        chk($sformatf("t4_grant%0d_is_d", k), d_gnt_o, exp4[k]);
        k++;
      end
    end
    chk("t4_grant_count", k, 4);
    drain();
    // Word store: write returns zero data
    cycle(0, 0, 1, 2'b11, 32'h20, 32'h1234, 0, 0);
    chk("t3_d_gnt", d_gnt_o, 1);
    idle(0);
    chk("t3_mem_we", mem_we_o, 2'b11);
    chk("t3_mem_wdata", mem_wdata_o, 32'h1234);
    chk("t3_mem_addr", mem_addr_o, 32'h20);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    idle(0);
    chk("t3_d_rvalid", d_rvalid_o, 1);
    chk("t3_d_rdata", d_rdata_o, 0);
    // D request dropped while busy for IF, then a stray ack in idle
    cycle(1, 32'h400, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'b00, 32'h500, 0, 0, 0);
    chk("t6_d_gnt_busy", d_gnt_o, 0);
    idle(0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h55);
    idle(0);
    chk("t6_if_rvalid", if_rvalid_o, 1);
    chk("t6_d_rvalid", d_rvalid_o, 0);
    idle(1);
    idle(0);
    chk("t6_stray_if_rvalid", if_rvalid_o, 0);
    chk("t6_stray_d_rvalid", d_rvalid_o, 0);
    chk("t6_stray_mem_req", mem_req_o, 0);
    cycle(0, 0, 1, 2'b00, 32'h600, 0, 0, 0);
    chk("t6_d_gnt_idle", d_gnt_o, 1);
    drain();
    // Reset while BUSY, late ack after release
    cycle(1, 32'h700, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("t5_mem_req_busy", mem_req_o, 1);
    @(negedge clk);
    #2 rst_i = 1;
    #1;
    chk("t5_mem_req_async", mem_req_o, 0);
    m_reset();
    @(negedge clk);
    rst_i = 0;
    idle(1);
    idle(0);
    chk("t5_if_rvalid", if_rvalid_o, 0);
    cycle(1, 32'h800, 0, 0, 0, 0, 0, 0);
    chk("t5_if_gnt_idle", if_gnt_o, 1);
    drain();
    // Random traffic with variable latency, dropped requests and stray acks
    ip = 0; dp = 0; wc = 0; ia = 0; da = 0; dd = 0; dw = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(2) == 0) begin ip = 1; ia = $urandom; end
      else if (ip && $urandom_range(15) == 0) ip = 0;
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1; da = $urandom; dd = $urandom; dw = 2'($urandom_range(3));
      end else if (dp && $urandom_range(15) == 0) dp = 0;
      ak = m_busy ? (wc == 0) : ($urandom_range(7) == 0);
      if (m_busy && wc > 0) wc--;
      was_busy = m_busy;
      cycle(ip, ia, dp, dw, da, dd, ak, $urandom);
      if (m_if_g) ip = 0;
      if (m_d_g) dp = 0;
      if (!was_busy && m_busy) wc = $urandom_range(3);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
